// File: rtl/char_match_sched.sv
// Character recogniser sequencer: scans a template ROM once per latched character,
// keeps the closest Hamming-distance match and publishes eight ASCII results together.
module char_match_sched #(
    parameter int          N_TMPL       = 36,
    parameter logic [2:0]  START_FRAME  = 3'd3,
    parameter logic [7:0]  REJECT_ASCII = 8'h3F
) (
    input  logic        pixelclk,
    input  logic        reset_n,
    input  logic        i_vsync,
    input  logic [2:0]  i_frame_cnt,
    input  logic [5:0]  i_max_dist,
    input  logic [39:0] i_char1,
    input  logic [39:0] i_char2,
    input  logic [39:0] i_char3,
    input  logic [39:0] i_char4,
    input  logic [39:0] i_char5,
    input  logic [39:0] i_char6,
    input  logic [39:0] i_char7,
    input  logic [39:0] i_char8,
    output logic [5:0]  o_tmpl_addr,
    output logic        o_tmpl_rd,
    input  logic [39:0] i_tmpl_data,
    input  logic [7:0]  i_tmpl_ascii,
    output logic [7:0]  o_char_result1,
    output logic [7:0]  o_char_result2,
    output logic [7:0]  o_char_result3,
    output logic [7:0]  o_char_result4,
    output logic [7:0]  o_char_result5,
    output logic [7:0]  o_char_result6,
    output logic [7:0]  o_char_result7,
    output logic [7:0]  o_char_result8,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_overrun
);

    localparam logic [5:0] LAST_ADDR = 6'(N_TMPL - 1);

    typedef enum logic [2:0] {IDLE, SCAN, LAST, STORE, DONE} state_t;

    state_t      state_q;
    logic        vsync_q;
    logic [39:0] chars_q [8];
    logic [2:0]  charIdx_q;
    logic [5:0]  tmplAddr_q;
    logic        rd_q;
    logic        cmpValid_q;
    logic        cmpFirst_q;
    logic [5:0]  bestDist_q;
    logic [7:0]  bestAscii_q;
    logic [7:0]  shadow_q [8];
    logic [7:0]  result_q [8];
    logic        busy_q;
    logic        done_q;
    logic        overrun_q;

    logic        start;
    logic [39:0] curChar;
    logic [5:0]  dist_d;
    logic [7:0]  storeVal_d;

    function automatic logic [5:0] popcount40(input logic [39:0] v);
        logic [5:0] c;
        c = '0;
        for (int i = 0; i < 40; i++) begin
            c = c + {5'b0, v[i]};
        end
        return c;
    endfunction

    assign start   = !i_vsync && vsync_q && (i_frame_cnt == START_FRAME);
    assign curChar = chars_q[charIdx_q];

    always_comb begin
        dist_d     = popcount40(curChar ^ i_tmpl_data);
        storeVal_d = REJECT_ASCII;
        if (curChar == '0) begin
            storeVal_d = 8'h20;
        end else if (bestDist_q <= i_max_dist) begin
            storeVal_d = bestAscii_q;
        end
    end

    always_ff @(posedge pixelclk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            vsync_q     <= 1'b0;
            charIdx_q   <= '0;
            tmplAddr_q  <= '0;
            rd_q        <= 1'b0;
            cmpValid_q  <= 1'b0;
            cmpFirst_q  <= 1'b0;
            bestDist_q  <= '0;
            bestAscii_q <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                chars_q[i]  <= '0;
                shadow_q[i] <= 8'h00;
                result_q[i] <= 8'h00;
            end
        end else begin
            vsync_q    <= i_vsync;
            done_q     <= 1'b0;
            overrun_q  <= start && (state_q != IDLE);
            cmpValid_q <= rd_q;
            cmpFirst_q <= rd_q && (tmplAddr_q == 6'd0);

            // ROM data arrives one cycle after its read; ascending scan makes strict-less keep the lowest address on ties
            if (cmpValid_q && (cmpFirst_q || (dist_d < bestDist_q))) begin
                bestDist_q  <= dist_d;
                bestAscii_q <= i_tmpl_ascii;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        chars_q[0] <= i_char1;
                        chars_q[1] <= i_char2;
                        chars_q[2] <= i_char3;
                        chars_q[3] <= i_char4;
                        chars_q[4] <= i_char5;
                        chars_q[5] <= i_char6;
                        chars_q[6] <= i_char7;
                        chars_q[7] <= i_char8;
                        charIdx_q  <= '0;
                        tmplAddr_q <= '0;
                        rd_q       <= 1'b1;
                        busy_q     <= 1'b1;
                        state_q    <= SCAN;
                    end
                end
                SCAN: begin
                    if (tmplAddr_q == LAST_ADDR) begin
                        rd_q       <= 1'b0;
                        tmplAddr_q <= '0;
                        state_q    <= LAST;
                    end else begin
                        tmplAddr_q <= tmplAddr_q + 6'd1;
                    end
                end
                LAST: begin
                    state_q <= STORE;
                end
                STORE: begin
                    shadow_q[charIdx_q] <= storeVal_d;
                    if (charIdx_q == 3'd7) begin
                        // Publish on entry to DONE so results and o_done are visible in the DONE cycle itself
                        for (int i = 0; i < 7; i++) begin
                            result_q[i] <= shadow_q[i];
                        end
                        result_q[7] <= storeVal_d;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        charIdx_q  <= charIdx_q + 3'd1;
                        tmplAddr_q <= '0;
                        rd_q       <= 1'b1;
                        state_q    <= SCAN;
                    end
                end
                DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign o_tmpl_addr    = tmplAddr_q;
    assign o_tmpl_rd      = rd_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_overrun      = overrun_q;
    assign o_char_result1 = result_q[0];
    assign o_char_result2 = result_q[1];
    assign o_char_result3 = result_q[2];
    assign o_char_result4 = result_q[3];
    assign o_char_result5 = result_q[4];
    assign o_char_result6 = result_q[5];
    assign o_char_result7 = result_q[6];
    assign o_char_result8 = result_q[7];

endmodule

// File: tb/tb_char_match_sched.sv
// Bench for char_match_sched: ROM responder, vector table of passes and a done-time scoreboard
// of expected result sets, plus gating, overrun and mid-pass reset sequences.
module tb_char_match_sched;

    localparam int N_TMPL     = 36;
    localparam int DONE_CYCLE = 8 * (N_TMPL + 2) + 1;

    logic        pixelclk = 1'b0;
    logic        reset_n;
    logic        i_vsync;
    logic [2:0]  i_frame_cnt;
    logic [5:0]  i_max_dist;
    logic [39:0] i_char1, i_char2, i_char3, i_char4, i_char5, i_char6, i_char7, i_char8;
    logic [5:0]  o_tmpl_addr;
    logic        o_tmpl_rd;
    logic [39:0] i_tmpl_data;
    logic [7:0]  i_tmpl_ascii;
    logic [7:0]  o_char_result1, o_char_result2, o_char_result3, o_char_result4;
    logic [7:0]  o_char_result5, o_char_result6, o_char_result7, o_char_result8;
    logic        o_busy, o_done, o_overrun;

    logic [39:0] romData [64];
    logic [7:0]  romAscii [64];
    logic [7:0][7:0] results;
    logic [63:0] expQ [$];

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic [7:0][39:0] ch;
        logic [5:0]       maxd;
        logic [7:0][7:0]  exp;
    } vec_t;

    vec_t vecs [5];

    char_match_sched #(
        .N_TMPL(N_TMPL), .START_FRAME(3'd3), .REJECT_ASCII(8'h3F)
    ) dut (
        .pixelclk(pixelclk), .reset_n(reset_n), .i_vsync(i_vsync),
        .i_frame_cnt(i_frame_cnt), .i_max_dist(i_max_dist),
        .i_char1(i_char1), .i_char2(i_char2), .i_char3(i_char3), .i_char4(i_char4),
        .i_char5(i_char5), .i_char6(i_char6), .i_char7(i_char7), .i_char8(i_char8),
        .o_tmpl_addr(o_tmpl_addr), .o_tmpl_rd(o_tmpl_rd),
        .i_tmpl_data(i_tmpl_data), .i_tmpl_ascii(i_tmpl_ascii),
        .o_char_result1(o_char_result1), .o_char_result2(o_char_result2),
        .o_char_result3(o_char_result3), .o_char_result4(o_char_result4),
        .o_char_result5(o_char_result5), .o_char_result6(o_char_result6),
        .o_char_result7(o_char_result7), .o_char_result8(o_char_result8),
        .o_busy(o_busy), .o_done(o_done), .o_overrun(o_overrun)
    );

    always #5 pixelclk = ~pixelclk;

    assign results = {o_char_result8, o_char_result7, o_char_result6, o_char_result5,
                      o_char_result4, o_char_result3, o_char_result2, o_char_result1};

    // Template ROM with one-cycle read latency; junk on the bus when not reading
    always @(posedge pixelclk) begin
        if (o_tmpl_rd) begin
            i_tmpl_data  <= romData[o_tmpl_addr];
            i_tmpl_ascii <= romAscii[o_tmpl_addr];
        end else begin
            i_tmpl_data  <= 40'({$urandom(), $urandom()});
            i_tmpl_ascii <= 8'($urandom());
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge pixelclk) begin
        if (reset_n && !o_tmpl_rd) checkOutput("addr_zero_when_idle", 64'(o_tmpl_addr), 64'd0);
        if (o_done) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_done", 64'(o_done), 64'd0);
            end else begin
                checkOutput("results_at_done", results, expQ.pop_front());
            end
        end
    end

    task automatic setChars(input logic [7:0][39:0] ch);
        i_char1 = ch[0]; i_char2 = ch[1]; i_char3 = ch[2]; i_char4 = ch[3];
        i_char5 = ch[4]; i_char6 = ch[5]; i_char7 = ch[6]; i_char8 = ch[7];
    endtask

    task automatic applyStimulus(input vec_t v, input bit doOverrun, input bit doReset);
        int doneCycle;
        int overruns;
        doneCycle = 0;
        overruns  = 0;
        @(negedge pixelclk);
        setChars(v.ch);
        i_max_dist  = v.maxd;
        i_frame_cnt = 3'd3;
        i_vsync     = 1'b1;
        @(negedge pixelclk);
        i_vsync = 1'b0;
        if (!doReset) expQ.push_back(v.exp);
        for (int k = 1; k <= 400; k++) begin
            @(negedge pixelclk);
            if (o_done && doneCycle == 0) doneCycle = k;
            if (o_overrun) overruns++;
            if (k == 1) checkOutput("busy_rd_cycle1", {62'd0, o_busy, o_tmpl_rd}, 64'd3);
            if (k == 10) setChars({8{40'({$urandom(), $urandom()})}});
            if (doOverrun && k == 98) i_vsync = 1'b1;
            if (doOverrun && k == 99) i_vsync = 1'b0;
            if (doReset && k == 149) reset_n = 1'b0;
            if (doReset && k == 150) begin
                checkOutput("reset_busy_done", {62'd0, o_busy, o_done}, 64'd0);
                checkOutput("reset_results", results, 64'd0);
                reset_n = 1'b1;
            end
            if (!doReset && doneCycle != 0 && k >= doneCycle + 20) break;
        end
        if (doReset) begin
            checkOutput("no_done_after_reset", 64'(doneCycle), 64'd0);
        end else begin
            checkOutput("done_latency", 64'(doneCycle), 64'(DONE_CYCLE));
            checkOutput("results_hold", results, v.exp);
        end
        checkOutput("overrun_pulses", 64'(overruns), doOverrun ? 64'd1 : 64'd0);
    endtask

    initial begin
        bit active;
        for (int a = 0; a < 64; a++) begin
            romData[a]  = 40'hFF_FFFF_FFFF;
            romAscii[a] = 8'(128 + a);
        end
        romData[2]  = 40'h00_0000_00FF; romAscii[2]  = 8'h42;
        romData[5]  = 40'h0F_0F0F_0F0F; romAscii[5]  = 8'h41;
        romData[9]  = 40'h00_0000_FF00; romAscii[9]  = 8'h43;
        romData[35] = 40'hAA_AAAA_AAAA; romAscii[35] = 8'h5A;

        vecs[0].ch   = {8{40'h0F_0F0F_0F0F}};
        vecs[0].maxd = 6'd3;
        vecs[0].exp  = {8{8'h41}};
        for (int i = 1; i < 5; i++) begin
            vecs[i].ch = {40'h00_0000_00F0, 40'hFF_FFFF_FFFE, 40'hAA_AAAA_AAAA, 40'hFF_FFFF_FFFF,
                          40'h00_0000_00F0, 40'h00_0000_0F0F, 40'h00_0000_0000, 40'h0F_0F0F_0F0F};
        end
        vecs[1].maxd = 6'd3; vecs[1].exp = {8'h3F, 8'h80, 8'h5A, 8'h80, 8'h3F, 8'h3F, 8'h20, 8'h41};
        vecs[2].maxd = 6'd8; vecs[2].exp = {8'h42, 8'h80, 8'h5A, 8'h80, 8'h42, 8'h42, 8'h20, 8'h41};
        vecs[3].maxd = 6'd4; vecs[3].exp = {8'h42, 8'h80, 8'h5A, 8'h80, 8'h42, 8'h3F, 8'h20, 8'h41};
        vecs[4].maxd = 6'd0; vecs[4].exp = {8'h3F, 8'h3F, 8'h5A, 8'h80, 8'h3F, 8'h3F, 8'h20, 8'h41};

        reset_n = 1'b0; i_vsync = 1'b0; i_frame_cnt = 3'd0; i_max_dist = 6'd0;
        setChars('0);
        repeat (3) @(posedge pixelclk);
        @(negedge pixelclk);
        checkOutput("reset_flags", {60'd0, o_busy, o_done, o_overrun, o_tmpl_rd}, 64'd0);
        checkOutput("reset_addr", 64'(o_tmpl_addr), 64'd0);
        checkOutput("reset_results", results, 64'd0);
        reset_n = 1'b1;

        for (int i = 0; i < 5; i++) applyStimulus(vecs[i], 1'b0, 1'b0);

        $display("[TB] gating: vsync fall with frame 2");
        active = 1'b0;
        @(negedge pixelclk);
        i_frame_cnt = 3'd2; i_vsync = 1'b1;
        @(negedge pixelclk);
        i_vsync = 1'b0;
        repeat (50) begin
            @(negedge pixelclk);
            if (o_busy || o_tmpl_rd) active = 1'b1;
        end
        checkOutput("gated_no_activity", 64'(active), 64'd0);

        $display("[TB] overrun during pass");
        applyStimulus(vecs[2], 1'b1, 1'b0);
        $display("[TB] reset mid-pass");
        applyStimulus(vecs[0], 1'b0, 1'b1);
        checkOutput("scoreboard_empty", 64'(expQ.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/char_match_sched.md
CHAR_MATCH_SCHED -- requirements
Module: char_match_sched

Interface
REQ-001 SHALL have parameter N_TMPL, default 36, number of template entries scanned per character (2..63).
REQ-002 SHALL have parameter START_FRAME, default 3'd3, the i_frame_cnt value that enables a recognition pass.
REQ-003 SHALL have parameter REJECT_ASCII, default 8'h3F, the code output when no template is close enough.
REQ-004 pixelclk  in  1  sole clock; all logic on rising edge.
REQ-005 reset_n  in  1  synchronous, active-low reset.
REQ-006 i_vsync  in  1  frame sync; its falling edge marks end of frame.
REQ-007 i_frame_cnt  in  3  current frame index.
REQ-008 i_max_dist  in  6  maximum accepted Hamming distance.
REQ-009 i_char1..i_char8  in  40 each  binarised character bitmaps.
REQ-010 o_tmpl_addr  out  6  template ROM address.
REQ-011 o_tmpl_rd  out  1  template read strobe.
REQ-012 i_tmpl_data  in  40  template bitmap, valid exactly 1 cycle after the o_tmpl_rd cycle.
REQ-013 i_tmpl_ascii  in  8  template ASCII code, same timing as i_tmpl_data.
REQ-014 o_char_result1..o_char_result8  out  8 each  recognised ASCII codes.
REQ-015 o_busy  out  1  pass in progress.
REQ-016 o_done  out  1  one-cycle pulse when results update.
REQ-017 o_overrun  out  1  one-cycle pulse when a start is dropped.

Function
REQ-018 SHALL register i_vsync each cycle; start condition = i_vsync low AND registered i_vsync high AND i_frame_cnt == START_FRAME.
REQ-019 FSM states SHALL be IDLE, SCAN, LAST, STORE, DONE.
REQ-020 IDLE: on start, SHALL latch i_char1..8 into internal copies, clear char index to 0, clear template index and go to SCAN.
REQ-021 SCAN: SHALL assert o_tmpl_rd with o_tmpl_addr = 0..N_TMPL-1, one address per cycle, for N_TMPL cycles, then go to LAST.
REQ-022 Each cycle following an o_tmpl_rd cycle, SHALL compute dist = popcount(latched char XOR i_tmpl_data), 6 bits.
REQ-023 Best-match tracking: first returned entry always loads; later entries replace only if dist strictly less (ties keep lowest address).
REQ-024 LAST: SHALL perform the compare for the final entry, with o_tmpl_rd low, then go to STORE.
REQ-025 STORE: shadow result for the current char = 8'h20 if the latched char is all-zero; else best ASCII if best dist <= i_max_dist; else REJECT_ASCII.
REQ-026 STORE: if char index == 7, SHALL go to DONE; else SHALL increment char index and go to SCAN.
REQ-027 DONE: SHALL copy all 8 shadow results to o_char_result1..8 simultaneously, assert o_done for one cycle and go to IDLE.
REQ-028 Latency: o_done SHALL be high in cycle 8*(N_TMPL+2)+1 after the latching edge (305 for N_TMPL=36).
REQ-029 o_busy SHALL be high in every state except IDLE.
REQ-030 A start condition in any state other than IDLE SHALL be ignored (pass continues unchanged) and SHALL pulse o_overrun for one cycle.
REQ-031 Input char changes after latching SHALL NOT affect the current pass.
REQ-032 o_char_result outputs SHALL hold their values between DONE cycles.
REQ-033 o_tmpl_addr SHALL be 0 whenever o_tmpl_rd is low.

Reset
REQ-034 While reset_n is low at a clock edge: FSM SHALL be IDLE; all o_char_result and shadow registers SHALL be 8'h00; o_busy, o_done, o_overrun, o_tmpl_rd SHALL be 0; o_tmpl_addr SHALL be 0; registered i_vsync SHALL be 0.
REQ-035 Reset asserted mid-pass SHALL abort the pass, with no o_done and no partial result update.

Verification
REQ-036 Exact match: template 5 = 40'h0F0F0F0F0F with ASCII 8'h41, i_char1..8 = that value, i_max_dist = 3 -> all results 8'h41, o_done at cycle 305.
REQ-037 Threshold: char differs by 4 bits from its nearest template, i_max_dist = 3 -> 8'h3F; with i_max_dist = 4 -> the template's ASCII.
REQ-038 Tie and blank: two templates at equal distance (addresses 2 and 9) -> ASCII of address 2; an all-zero char -> 8'h20.
REQ-039 Gating: vsync fall with i_frame_cnt = 2 -> no o_tmpl_rd and o_busy stays 0; a second vsync fall at cycle 100 of a pass -> o_overrun pulse, o_done still at cycle 305.
REQ-040 Reset mid-pass: reset_n low at cycle 150 -> o_busy = 0 and results 8'h00 on the next edge; no o_done occurs.
